// File: rtl/axi_wr_arbiter_if.sv
// Write-channel handshake bundle between NM upstream AXI masters, the arbiter and the shared slave port.
interface axi_wr_arbiter_if #(
  parameter int NM = 4
);
  logic [NM-1:0]   m_awvalid;
  logic [NM-1:0]   m_awready;
  logic [8*NM-1:0] m_awlen;
  logic [NM-1:0]   m_wvalid;
  logic [NM-1:0]   m_wlast;
  logic [NM-1:0]   m_wready;
  logic [NM-1:0]   m_bvalid;
  logic [NM-1:0]   m_bready;
  logic            s_awvalid;
  logic            s_awready;
  logic            s_wvalid;
  logic            s_wlast;
  logic            s_wready;
  logic            s_bvalid;
  logic            s_bready;

  // slave: the arbiter's side (answers the masters, drives the shared slave port)
  modport slave (
    input  m_awvalid, m_awlen, m_wvalid, m_wlast, m_bready,
    input  s_awready, s_wready, s_bvalid,
    output m_awready, m_wready, m_bvalid,
    output s_awvalid, s_wvalid, s_wlast, s_bready
  );

  // master: the surrounding masters and slave port that talk to the arbiter
  modport master (
    output m_awvalid, m_awlen, m_wvalid, m_wlast, m_bready,
    output s_awready, s_wready, s_bvalid,
    input  m_awready, m_wready, m_bvalid,
    input  s_awvalid, s_wvalid, s_wlast, s_bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: one master owns the shared AW/W/B port from address through response.
module axi_wr_arbiter #(
  parameter int NM = 4,
  parameter int SW = $clog2(NM)
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  axi_wr_arbiter_if.slave bus,
  output logic [SW-1:0]   sel,
  output logic [NM-1:0]   grant,
  output logic            busy,
  output logic            len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    len_q, len_d;
  logic          len_err_q, len_err_d;
  logic          busy_q, busy_d;

  logic [SW-1:0] win;
  logic          found;
  int            idx;

  // Search starts just after the last served master, so it becomes lowest priority.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(rr_q) + k) % NM;
      if (!found && bus.m_awvalid[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    len_err_d     = len_err_q;
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_bvalid  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_wlast   = 1'b0;
    bus.s_bready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          grant_d = NM'(1) << win;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.s_awvalid         = bus.m_awvalid[sel_q];
        bus.m_awready[sel_q]  = bus.s_awready;
        if (bus.m_awvalid[sel_q] && bus.s_awready) begin
          len_d   = bus.m_awlen[8*int'(sel_q) +: 8];
          cnt_d   = 8'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.s_wvalid         = bus.m_wvalid[sel_q];
        bus.s_wlast          = bus.m_wlast[sel_q];
        bus.m_wready[sel_q]  = bus.s_wready;
        // cnt_q holds the number of beats already accepted, so the last beat expects cnt_q == len_q.
        if (bus.m_wvalid[sel_q] && bus.s_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.m_wlast[sel_q]) begin
            state_d = RESP;
            if (cnt_q != len_q) len_err_d = 1'b1;
          end else if (cnt_q == len_q) begin
            len_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        bus.m_bvalid[sel_q] = bus.s_bvalid;
        bus.s_bready        = bus.m_bready[sel_q];
        if (bus.s_bvalid && bus.m_bready[sel_q]) begin
          rr_d    = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= SW'(NM - 1);
      grant_q   <= '0;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      busy_q    <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter against a transaction-level round-robin reference model.
module tb_axi_wr_arbiter;
  localparam int NM = 4;
  localparam int SW = $clog2(NM);

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [SW-1:0] sel;
  logic [NM-1:0] grant;
  logic          busy;
  logic          len_err;

  axi_wr_arbiter_if #(.NM(NM)) bus ();

  axi_wr_arbiter #(.NM(NM)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, last served master, sticky length error, B deliveries.
  logic [NM-1:0] req;
  int alen   [NM];
  int nbeats [NM];
  int ptr_m;
  bit err_m;
  int bexp [NM];
  int bobs [NM];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] r, input int p);
    for (int k = 1; k <= NM; k++)
      if (r[(p + k) % NM]) return (p + k) % NM;
    return -1;
  endfunction

  task automatic drive_req();
    bus.m_awvalid = req;
    for (int i = 0; i < NM; i++) bus.m_awlen[8*i +: 8] = 8'(alen[i]);
  endtask

  task automatic add_req(input int m, input int l, input int n);
    req[m]    = 1'b1;
    alen[m]   = l;
    nbeats[m] = n;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    ptr_m = NM - 1;
    err_m = 1'b0;
  endtask

  // One full transaction. aw_stall/b_delay < 0 mean random; wmode 0 random, 1 toggled wready, 2 no stalls.
  task automatic do_txn(input int aw_stall, input int b_delay, input int wmode,
                        input int abort_at, output int got_sel);
    int w, b, fwd, cyc;
    logic hs, wv, sr, last, bv, br;
    logic [NM-1:0] mask;
    got_sel = -1;
    drive_req();
    w    = pick(req, ptr_m);
    mask = NM'(1) << w;
    #1;
    check_eq("idle_grant", grant, '0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_s_awvalid", bus.s_awvalid, 1'b0);
    @(negedge ACLK);
    check_eq("grant", grant, mask);
    check_eq("sel", sel, w);
    check_eq("busy", busy, 1'b1);
    got_sel = int'(sel);

    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 40) begin
      bus.s_awready = (aw_stall >= 0) ? (cyc >= aw_stall) : ($urandom_range(0, 99) < 50);
      #1;
      check_eq("aw_valid", bus.s_awvalid, 1'b1);
      check_eq("aw_ready_route", bus.m_awready, bus.s_awready ? mask : '0);
      check_eq("aw_grant_held", grant, mask);
      hs = bus.s_awready;
      cyc++;
      @(negedge ACLK);
    end
    check_eq("aw_done", hs, 1'b1);
    req[w] = 1'b0;
    bus.s_awready = 1'b0;
    drive_req();

    b = 0; fwd = 0; cyc = 0;
    while (b < nbeats[w] && cyc < 200) begin
      if (abort_at >= 0 && b == abort_at) begin
        bus.m_wvalid = '0; bus.m_wlast = '0; bus.s_wready = 1'b0;
        ARESETn = 1'b0;
        #1;
        check_eq("rst_grant", grant, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sel", sel, '0);
        check_eq("rst_s_awvalid", bus.s_awvalid, 1'b0);
        check_eq("rst_s_wvalid", bus.s_wvalid, 1'b0);
        check_eq("rst_s_bready", bus.s_bready, 1'b0);
        check_eq("rst_len_err", len_err, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        ptr_m = NM - 1;
        err_m = 1'b0;
        return;
      end
      wv   = (wmode == 0) ? ($urandom_range(0, 99) < 70) : 1'b1;
      sr   = (wmode == 0) ? ($urandom_range(0, 99) < 60) : (wmode == 1) ? (cyc % 2 == 0) : 1'b1;
      last = (b == nbeats[w] - 1);
      bus.m_wvalid = (NM'($urandom) & ~mask) | (wv ? mask : '0);
      bus.m_wlast  = (NM'($urandom) & ~mask) | (last ? mask : '0);
      bus.s_wready = sr;
      #1;
      check_eq("w_valid", bus.s_wvalid, wv);
      check_eq("w_last", bus.s_wlast, last);
      check_eq("w_ready_route", bus.m_wready, sr ? mask : '0);
      check_eq("w_grant_held", grant, mask);
      if (bus.s_wvalid && bus.s_wready) fwd++;
      if (wv && sr) b++;
      cyc++;
      @(negedge ACLK);
    end
    check_eq("w_count", fwd, nbeats[w]);
    if (nbeats[w] != alen[w] + 1) err_m = 1'b1;
    bus.m_wvalid = '0; bus.m_wlast = '0; bus.s_wready = 1'b0;
    #1;
    check_eq("resp_len_err", len_err, err_m);
    check_eq("resp_s_wvalid", bus.s_wvalid, 1'b0);
    check_eq("resp_busy", busy, 1'b1);

    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 40) begin
      bv = (b_delay >= 0) ? (cyc >= b_delay) : ($urandom_range(0, 3) == 0);
      br = (wmode == 0) ? ($urandom_range(0, 99) < 70) : 1'b1;
      bus.s_bvalid = bv;
      bus.m_bready = (NM'($urandom) & ~mask) | (br ? mask : '0);
      #1;
      check_eq("b_valid_route", bus.m_bvalid, bv ? mask : '0);
      check_eq("b_ready", bus.s_bready, br);
      check_eq("b_grant_held", grant, mask);
      for (int i = 0; i < NM; i++)
        if (bus.m_bvalid[i] && bus.m_bready[i]) bobs[i]++;
      hs = bv && br;
      cyc++;
      @(negedge ACLK);
    end
    check_eq("b_done", hs, 1'b1);
    bexp[w]++;
    ptr_m = w;
    bus.s_bvalid = 1'b0;
    bus.m_bready = '0;
    #1;
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_grant", grant, '0);
  endtask

  initial begin
    int g;
    ARESETn = 1'b0;
    bus.m_awvalid = '0; bus.m_awlen = '0; bus.m_wvalid = '0; bus.m_wlast = '0;
    bus.m_bready = '0; bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0;
    req = '0;
    for (int i = 0; i < NM; i++) begin
      alen[i] = 0; nbeats[i] = 1; bexp[i] = 0; bobs[i] = 0;
    end
    ptr_m = NM - 1;
    err_m = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    check_eq("reset_grant", grant, '0);
    check_eq("reset_sel", sel, '0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_len_err", len_err, 1'b0);
    check_eq("reset_s_awvalid", bus.s_awvalid, 1'b0);
    check_eq("reset_s_wvalid", bus.s_wvalid, 1'b0);
    check_eq("reset_s_bready", bus.s_bready, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Single write from master 2, four beats.
    add_req(2, 3, 4);
    do_txn(0, 0, 2, -1, g);
    check_eq("single_sel", g, 2);

    // All masters contend continuously: fair order from a fresh reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NM; i++) if (!req[i]) add_req(i, 0, 1);
      do_txn(-1, -1, 0, -1, g);
      check_eq("rr_order", g, k % NM);
    end
    req = '0;
    drive_req();

    // After master 2 completes, simultaneous 1 and 3 resolve to 3 first.
    add_req(2, 1, 2);
    do_txn(-1, -1, 0, -1, g);
    check_eq("ptr_first", g, 2);
    add_req(1, 0, 1);
    add_req(3, 0, 1);
    do_txn(-1, -1, 0, -1, g);
    check_eq("ptr_second", g, 3);
    do_txn(-1, -1, 0, -1, g);
    check_eq("ptr_third", g, 1);

    // Backpressure on every channel.
    add_req(0, 3, 4);
    do_txn(5, 3, 1, -1, g);
    check_eq("bp_sel", g, 0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NM; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          int l;
          l = $urandom_range(0, 4);
          add_req(i, l, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : l + 1);
        end
      end
      if (req == '0) add_req($urandom_range(0, NM - 1), 1, 2);
      do_txn(-1, -1, 0, -1, g);
    end
    req = '0;
    drive_req();

    // Length mismatch is sticky across a following clean transaction.
    do_reset();
    #1;
    add_req(1, 3, 2);
    do_txn(0, 0, 2, -1, g);
    check_eq("len_err_set", len_err, 1'b1);
    add_req(2, 0, 1);
    do_txn(0, 0, 2, -1, g);
    check_eq("len_err_sticky", len_err, 1'b1);

    // Reset after beat 2 of 4, then master 0 wins first.
    add_req(3, 3, 4);
    do_txn(0, 0, 2, 2, g);
    req = '0;
    for (int i = 0; i < NM; i++) add_req(i, 0, 1);
    do_txn(0, 0, 2, -1, g);
    check_eq("post_reset_first", g, 0);
    req = '0;
    drive_req();

    for (int i = 0; i < NM; i++) check_eq("b_count", bobs[i], bexp[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
